// File: rtl/seg7_capture_decoder.sv
// Samples an asynchronous 7-segment bus, waits for it to settle, decodes it to a digit
// and offers each new pattern once over valid/ready. Define SEG7_ACTIVE_LOW_EN for common-anode buses.
module seg7_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_digit,
  output logic             out_blank,
  output logic             out_invalid,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {SETTLE, REPORT, HOLD} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  state_t           state_q;
  logic [6:0]       sync1_q, sync2_q, seg_s;
  logic [6:0]       last_q, rep_q;
  logic [2:0]       vld_q;
  logic [7:0]       cnt_q;
  logic             chg_q, rep_vld_q;
  logic             valid_q, blank_q, invalid_q;
  logic [3:0]       digit_q;
  logic [ERR_W-1:0] err_q;

  logic [7:0] cnt_inc_d;
  logic       differs_d, fresh_d, stable_hit_d, new_pat_d, capture_d;
  logic [3:0] dec_digit_d;
  logic       dec_blank_d, dec_invalid_d;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_s = ~sync2_q;
`else
  assign seg_s = sync2_q;
`endif

  always_comb begin
    dec_digit_d   = 4'hF;
    dec_blank_d   = 1'b0;
    dec_invalid_d = 1'b0;
    case (seg_s)
      7'h3F: dec_digit_d = 4'd0;
      7'h06: dec_digit_d = 4'd1;
      7'h5B: dec_digit_d = 4'd2;
      7'h4F: dec_digit_d = 4'd3;
      7'h66: dec_digit_d = 4'd4;
      7'h6D: dec_digit_d = 4'd5;
      7'h7D: dec_digit_d = 4'd6;
      7'h07: dec_digit_d = 4'd7;
      7'h7F: dec_digit_d = 4'd8;
      7'h67: dec_digit_d = 4'd9;
      7'h00: dec_blank_d = 1'b1;
      default: dec_invalid_d = 1'b1;
    endcase
  end

  // The first sample out of a freshly reset synchronizer counts as a new pattern,
  // so reset release sees the same latency as an input change.
  always_comb begin
    fresh_d      = vld_q[1] & ~vld_q[2];
    differs_d    = (seg_s != last_q);
    cnt_inc_d    = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
    stable_hit_d = (differs_d || fresh_d) ? (CNT_MAX == 8'd0) : (cnt_inc_d == CNT_MAX);
    new_pat_d    = !rep_vld_q || (seg_s != rep_q);
    capture_d    = ((state_q == SETTLE) && vld_q[1] && stable_hit_d && new_pat_d) ||
                   ((state_q == HOLD) && (seg_s != rep_q) && (CNT_MAX == 8'd0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SETTLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      vld_q     <= '0;
      last_q    <= '0;
      rep_q     <= '0;
      cnt_q     <= '0;
      chg_q     <= 1'b0;
      rep_vld_q <= 1'b0;
      valid_q   <= 1'b0;
      digit_q   <= '0;
      blank_q   <= 1'b0;
      invalid_q <= 1'b0;
      err_q     <= '0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[1:0], 1'b1};

      case (state_q)
        SETTLE: begin
          if (vld_q[1]) begin
            if (differs_d || fresh_d) begin
              last_q <= seg_s;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_inc_d;
            end
            // Settled on the pattern already reported: wait quietly for a change.
            if (stable_hit_d && !new_pat_d) state_q <= HOLD;
          end
        end
        REPORT: begin
          if (differs_d) begin
            last_q <= seg_s;
            cnt_q  <= '0;
            chg_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
          if (out_ready) begin
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            state_q <= (differs_d || chg_q || (seg_s != rep_q)) ? SETTLE : HOLD;
          end
        end
        HOLD: begin
          if (seg_s != rep_q) begin
            last_q  <= seg_s;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        default: state_q <= SETTLE;
      endcase

      if (capture_d) begin
        state_q   <= REPORT;
        valid_q   <= 1'b1;
        digit_q   <= dec_digit_d;
        blank_q   <= dec_blank_d;
        invalid_q <= dec_invalid_d;
        rep_q     <= seg_s;
        rep_vld_q <= 1'b1;
        chg_q     <= 1'b0;
        if (dec_invalid_d && (err_q != '1)) err_q <= err_q + 1'b1;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_digit   = digit_q;
  assign out_blank   = blank_q;
  assign out_invalid = invalid_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: settle latency, decode, backpressure,
// glitch rejection, invalid counting with saturation, and asynchronous reset.
module tb_seg7_capture_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in, seg2;
  logic       out_ready, ready2;
  logic       out_valid, out_blank, out_invalid;
  logic [3:0] out_digit;
  logic [7:0] err_count;
  logic       valid2, blank2, invalid2;
  logic [3:0] digit2;
  logic [1:0] err2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seg7_capture_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_digit(out_digit), .out_blank(out_blank),
    .out_invalid(out_invalid), .err_count(err_count)
  );

  seg7_capture_decoder #(.STABLE_CYCLES(4), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .seg_in(seg2), .out_ready(ready2),
    .out_valid(valid2), .out_digit(digit2), .out_blank(blank2),
    .out_invalid(invalid2), .err_count(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges, recording the edge index of the first valid and the data seen there.
  task automatic run_edges(input int n, output int first, output int pulses,
                           output logic [3:0] dig, output logic blk, output logic inv);
    first = 0; pulses = 0; dig = 4'h0; blk = 1'b0; inv = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (out_valid) begin
        pulses++;
        if (first == 0) begin
          first = i; dig = out_digit; blk = out_blank; inv = out_invalid;
        end
      end
    end
  endtask

  task automatic test_reset();
    int first, pulses; logic [3:0] dig; logic blk, inv;
    rst = 1'b1; seg_in = 7'h00; out_ready = 1'b1; seg2 = 7'h00; ready2 = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", out_valid); else passes++;
    checks++; if (out_digit !== 4'h0) $display("FAIL rst_digit: got %0h expected 0", out_digit); else passes++;
    checks++; if (err_count !== 8'h00) $display("FAIL rst_err: got %0h expected 0", err_count); else passes++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run_edges(8, first, pulses, dig, blk, inv);
    checks++; if (first !== 6) $display("FAIL reset_latency: got edge %0d expected 6", first); else passes++;
    checks++; if (pulses !== 1) $display("FAIL reset_pulses: got %0d expected 1", pulses); else passes++;
    checks++; if (blk !== 1'b1) $display("FAIL reset_blank: got %0b expected 1", blk); else passes++;
    checks++; if (dig !== 4'hF) $display("FAIL reset_digit: got %0h expected F", dig); else passes++;
    run_edges(12, first, pulses, dig, blk, inv);
    checks++; if (pulses !== 0) $display("FAIL idle_repeat: got %0d pulses expected 0", pulses); else passes++;
  endtask

  task automatic test_digit();
    int first, pulses; logic [3:0] dig; logic blk, inv;
    seg_in = 7'h5B;
    run_edges(10, first, pulses, dig, blk, inv);
    checks++; if (first !== 6) $display("FAIL digit_latency: got edge %0d expected 6", first); else passes++;
    checks++; if (pulses !== 1) $display("FAIL digit_pulses: got %0d expected 1", pulses); else passes++;
    checks++; if (dig !== 4'd2) $display("FAIL digit_value: got %0h expected 2", dig); else passes++;
    checks++; if (blk !== 1'b0 || inv !== 1'b0) $display("FAIL digit_flags: got blank=%0b invalid=%0b expected 0/0", blk, inv); else passes++;
    checks++; if (err_count !== 8'd0) $display("FAIL digit_err: got %0d expected 0", err_count); else passes++;
  endtask

  task automatic test_backpressure();
    int first, pulses, bad; logic [3:0] dig; logic blk, inv;
    out_ready = 1'b0; seg_in = 7'h4F; bad = 0;
    run_edges(10, first, pulses, dig, blk, inv);
    checks++; if (first !== 6 || dig !== 4'd3) $display("FAIL bp_first: got edge %0d digit %0h expected 6/3", first, dig); else passes++;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) seg_in = 7'h66;
      step();
      if (out_valid !== 1'b1 || out_digit !== 4'd3) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_handshake: got valid %0b expected 0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'd4) $display("FAIL bp_second: got valid %0b digit %0h expected 1/4", out_valid, out_digit); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_second_done: got valid %0b expected 0", out_valid); else passes++;
  endtask

  task automatic test_glitch();
    int first, pulses; logic [3:0] dig; logic blk, inv;
    seg_in = 7'h06;
    run_edges(10, first, pulses, dig, blk, inv);
    checks++; if (pulses !== 1 || dig !== 4'd1) $display("FAIL glitch_setup: got %0d pulses digit %0h expected 1/1", pulses, dig); else passes++;
    seg_in = 7'h7F;
    step(); step();
    seg_in = 7'h06;
    run_edges(15, first, pulses, dig, blk, inv);
    checks++; if (pulses !== 0) $display("FAIL glitch_reject: got %0d pulses expected 0", pulses); else passes++;
  endtask

  task automatic test_invalid();
    int first, pulses; logic [3:0] dig; logic blk, inv;
    seg_in = 7'h49;
    run_edges(10, first, pulses, dig, blk, inv);
    checks++; if (pulses !== 1 || dig !== 4'hF || inv !== 1'b1 || blk !== 1'b0)
      $display("FAIL invalid_first: got pulses=%0d digit=%0h inv=%0b blank=%0b expected 1/F/1/0", pulses, dig, inv, blk); else passes++;
    checks++; if (err_count !== 8'd1) $display("FAIL invalid_err1: got %0d expected 1", err_count); else passes++;
    seg_in = 7'h00;
    run_edges(10, first, pulses, dig, blk, inv);
    checks++; if (pulses !== 1 || blk !== 1'b1 || inv !== 1'b0) $display("FAIL invalid_blank: got pulses=%0d blank=%0b inv=%0b expected 1/1/0", pulses, blk, inv); else passes++;
    seg_in = 7'h49;
    run_edges(10, first, pulses, dig, blk, inv);
    checks++; if (pulses !== 1 || inv !== 1'b1 || dig !== 4'hF) $display("FAIL invalid_second: got pulses=%0d inv=%0b digit=%0h expected 1/1/F", pulses, inv, dig); else passes++;
    checks++; if (err_count !== 8'd2) $display("FAIL invalid_err2: got %0d expected 2", err_count); else passes++;
  endtask

  task automatic test_err_saturate();
    for (int k = 0; k < 5; k++) begin
      seg2 = 7'h49;
      repeat (10) step();
      seg2 = 7'h00;
      repeat (10) step();
      if (k == 1) begin
        checks++; if (err2 !== 2'd2) $display("FAIL sat_mid: got %0d expected 2", err2); else passes++;
      end
    end
    checks++; if (err2 !== 2'd3) $display("FAIL sat_final: got %0d expected 3", err2); else passes++;
  endtask

  task automatic test_reset_mid_report();
    int first, pulses; logic [3:0] dig; logic blk, inv;
    out_ready = 1'b0; seg_in = 7'h07;
    run_edges(10, first, pulses, dig, blk, inv);
    checks++; if (out_valid !== 1'b1 || dig !== 4'd7) $display("FAIL midrst_setup: got valid %0b digit %0h expected 1/7", out_valid, dig); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %0b expected 0", out_valid); else passes++;
    checks++; if (out_digit !== 4'h0) $display("FAIL midrst_digit: got %0h expected 0", out_digit); else passes++;
    checks++; if (err_count !== 8'd0) $display("FAIL midrst_err: got %0d expected 0", err_count); else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_digit();
    test_backpressure();
    test_glitch();
    test_invalid();
    test_err_saturate();
    test_reset_mid_report();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
Receive-side counterpart of the chip's BCD-to-seven-segment output path. The block samples a 7-line segment bus driven by an ALU chip output and waits for the pattern to settle. It then decodes the pattern back to a 4-bit digit and offers it once, over a valid/ready handshake, to a downstream consumer such as a scoreboard, logger or host readback register. Invalid patterns are flagged and counted.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold unchanged before capture; legal range 1..255
ERR_W, 8, width of the saturating invalid-pattern counter

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-high reset
seg_in  input  7  segment lines, bit0=a .. bit6=g, asynchronous to clk
out_ready  input  1  consumer accepts the current report
out_valid  output  1  report pending
out_digit  output  4  decoded digit 0..9; 4'hF for blank or invalid
out_blank  output  1  captured pattern was all segments off
out_invalid  output  1  captured pattern is neither a digit nor blank
err_count  output  ERR_W  saturating count of invalid captures

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0. Synchronizer flops, last-pattern register and stability counter are cleared. State is SETTLE with a last-pattern value of 7'h00.
- Input path: 2-flop synchronizer drives seg_s. After the optional polarity stage, all further logic uses seg_s only.
- Decode table (seg -> digit):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 67->9
  - 00 -> blank, out_digit=F
  - any other pattern -> invalid, out_digit=F
- States:
  - SETTLE: if seg_s differs from the last-pattern register, load the register and clear the counter. Otherwise increment the counter. When the counter reaches STABLE_CYCLES-1 with seg_s still equal, load the output registers with the decode, assert out_valid and go to REPORT. If the capture is invalid, increment err_count in the same cycle.
  - REPORT: out_valid, out_digit, out_blank and out_invalid stay stable until out_valid && out_ready. Input changes during REPORT are tracked in the last-pattern register; the counter restarts on each change. On handshake:
    - go to SETTLE if the tracked pattern differs from the reported one, or if it changed at any point during REPORT;
    - otherwise go to HOLD.
  - HOLD: out_valid=0 and the data outputs keep their last values. The first cycle seg_s differs from the reported pattern loads the last-pattern register, clears the counter and goes to SETTLE. The same pattern is never reported twice consecutively.
- Latency: seg_in changes and then holds constant. out_valid rises on the (2+STABLE_CYCLES)th rising edge after the first edge that samples the new value, provided the block is in SETTLE or HOLD.
- Glitch rejection: a change lasting fewer than STABLE_CYCLES synchronized cycles never produces a report.
- If out_ready is already high when out_valid rises, the handshake completes on that edge and out_valid is high for exactly 1 cycle.
- err_count saturates at 2^ERR_W-1 and never wraps. It is cleared only by rst.
- rst asserted mid-REPORT: pending report dropped, out_valid falls immediately (asynchronous).

Optional Feature:
SEG7_ACTIVE_LOW_EN
- Defined: seg_s is inverted after the synchronizer, so the block accepts common-anode (active-low) segment buses. A bus idling at 7'h7F decodes as blank. Reset value of the last-pattern register is unchanged (7'h00 post-inversion).
- Undefined: no inversion; segments are active-high as in the table above.

Test Plan:
- Reset released, seg_in=00 held, out_ready=1, STABLE_CYCLES=4 -> out_valid pulses once on edge 6 with out_blank=1, out_digit=F; no further reports while seg_in stays 00.
- seg_in 00->5B held, out_ready=1 -> one report, out_digit=2, out_blank=0, out_invalid=0, exactly 6 edges after change; err_count=0.
- seg_in 4F held, out_ready=0 for 20 cycles, seg_in->66 at cycle 10 -> out_digit holds 3 with out_valid=1 throughout; after out_ready=1 one handshake for 3, then a second report with out_digit=4.
- seg_in pulses to 7F for 2 cycles then back to 06 (already reported) -> no new report; out_valid stays 0.
- seg_in=49 (invalid) held, then 00, then 49 again, out_ready=1 -> two invalid reports with out_digit=F, out_invalid=1, err_count=2; with ERR_W=2 and 5 invalid captures, err_count=3.
- rst asserted while out_valid=1 -> out_valid, out_digit and err_count read 0 before the next clk edge.
